// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if
//   Bundles the requester side and FiFo push side of the push arbiter.
//   master : arbiter view (consumes requests/full, drives grant/push/data/status)
//   slave  : environment view (drives requests, data and full, observes the rest)
//   Signals:
//     io_req       [N]    per-requester push request
//     io_din       [N*W]  packed requester data, lane i at [i*W +: W]
//     io_fifo_full        FiFo full flag
//     io_grant     [N]    one-hot grant, bit i = lane i pushed this cycle
//     io_fifo_push        FiFo push strobe
//     io_fifo_din  [W]    FiFo write data
//     io_owner     [IW]   current burst owner (registered)
//     io_locked           burst held (registered)
interface fifo_push_arbiter_if #(
    parameter int N = 4,
    parameter int W = 2
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   io_req;
    logic [N*W-1:0] io_din;
    logic           io_fifo_full;
    logic [N-1:0]   io_grant;
    logic           io_fifo_push;
    logic [W-1:0]   io_fifo_din;
    logic [IW-1:0]  io_owner;
    logic           io_locked;

    modport master (
        input  io_req, io_din, io_fifo_full,
        output io_grant, io_fifo_push, io_fifo_din, io_owner, io_locked
    );

    modport slave (
        output io_req, io_din, io_fifo_full,
        input  io_grant, io_fifo_push, io_fifo_din, io_owner, io_locked
    );
endinterface

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//   Round-robin arbiter sharing one FiFo push port among N requesters.
//   A winner keeps the port for up to MAX_BURST consecutive pushes, stalls
//   (without losing ownership) while the FiFo is full, and gives the port up
//   after the burst limit or one cycle after it drops its request.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    fifo_push_arbiter_if.master (requests, data, full in;
//            grant, push, data, owner, locked out)
//   Grant/push/data are combinational from the inputs and registered state.
module fifo_push_arbiter #(
    parameter int N         = 4,
    parameter int W         = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_push_arbiter_if.master  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [IW-1:0]   last_reg,  last_next;
    logic [CW-1:0]   cnt_reg,   cnt_next;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic            grant_valid;
    logic [IW-1:0]   grant_idx;
    logic [W-1:0]    lane [N];

    // Unpack data lanes and decode the one-hot grant.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign lane[gi]         = bus.io_din[gi*W +: W];
            assign bus.io_grant[gi] = grant_valid && (grant_idx == IW'(gi));
        end
    endgenerate

    // Round-robin scan starting just after the last owner. Iterating from the
    // farthest candidate down lets the nearest requester overwrite the result.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = N; k >= 1; k--) begin
            idx = int'(last_reg) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = IW'(idx);
            if (bus.io_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            owner_reg <= '0;
            last_reg  <= IW'(N - 1);
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        last_next   = last_reg;
        cnt_next    = cnt_reg;
        grant_valid = 1'b0;
        grant_idx   = owner_reg;
        unique case (state_reg)
            IDLE: begin
                if (win_found && !bus.io_fifo_full) begin
                    grant_valid = 1'b1;
                    grant_idx   = win_idx;
                    owner_next  = win_idx;
                    cnt_next    = CW'(1);
                    // A single-push burst is complete immediately.
                    if (MAX_BURST == 1) begin
                        last_next = win_idx;
                    end else begin
                        state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (bus.io_req[owner_reg]) begin
                    // Full stalls the owner without releasing the lock.
                    if (!bus.io_fifo_full) begin
                        grant_valid = 1'b1;
                        if ((cnt_reg + CW'(1)) == CW'(MAX_BURST)) begin
                            state_next = IDLE;
                            last_next  = owner_reg;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CW'(1);
                        end
                    end
                end else begin
                    // Owner dropped: spend this cycle as a bubble, then rotate.
                    state_next = IDLE;
                    last_next  = owner_reg;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // The registers clear asynchronously; suppress the combinational grant
        // in the same instant so nothing is pushed while reset is high.
        if (reset) begin
            grant_valid = 1'b0;
        end
    end

    assign bus.io_fifo_push = grant_valid;
    assign bus.io_fifo_din  = grant_valid ? lane[grant_idx] : '0;
    assign bus.io_owner     = owner_reg;
    assign bus.io_locked    = (state_reg == LOCKED);
endmodule
